// File: rtl/count_seq_pkg.sv
// ---------------------------------------------------------------------------
// count_seq_pkg
// Shared definitions for the count_sequencer block: default datapath widths
// and the 2-bit binary state encoding of the sequencing FSM.
// Optional feature macro used by the block: COUNT_SEQ_PAUSE_EN.
// ---------------------------------------------------------------------------
package count_seq_pkg;

  localparam int unsigned DEF_WIDTH = 4;  // counter / limit width
  localparam int unsigned DEF_REPW  = 4;  // repeat-count width

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage : count_seq_pkg

// File: rtl/count_sequencer_if.sv
// ---------------------------------------------------------------------------
// count_sequencer_if
// Request/status bundle between a requesting unit (master) and the
// count_sequencer (slave).
//   start, abort, limit, reps : requester -> sequencer
//   pause                     : requester -> sequencer (COUNT_SEQ_PAUSE_EN only)
//   ready, busy, q, wrap, done: sequencer -> requester
// ---------------------------------------------------------------------------
interface count_sequencer_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned REPW  = 4
) ();

  logic             start;
  logic             abort;
`ifdef COUNT_SEQ_PAUSE_EN
  logic             pause;
`endif
  logic [WIDTH-1:0] limit;
  logic [REPW-1:0]  reps;
  logic             ready;
  logic             busy;
  logic [WIDTH-1:0] q;
  logic             wrap;
  logic             done;

`ifdef COUNT_SEQ_PAUSE_EN
  modport master (output start, abort, pause, limit, reps,
                  input  ready, busy, q, wrap, done);
  modport slave  (input  start, abort, pause, limit, reps,
                  output ready, busy, q, wrap, done);
`else
  modport master (output start, abort, limit, reps,
                  input  ready, busy, q, wrap, done);
  modport slave  (input  start, abort, limit, reps,
                  output ready, busy, q, wrap, done);
`endif

endinterface : count_sequencer_if

// File: rtl/seq_counter.sv
// ---------------------------------------------------------------------------
// seq_counter
// WIDTH-bit synchronous up-counter with synchronous clear and count enable.
// Clear has priority over enable. Wraps modulo 2^WIDTH.
//   clk    : rising-edge clock
//   reset  : asynchronous, active-low reset (count -> 0)
//   clear  : load 0 on the next edge
//   enable : increment on the next edge
//   q      : current count
// ---------------------------------------------------------------------------
module seq_counter
  import count_seq_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] count_d, count_q;

  // NOTE: every variable written here gets a default first, so no path
  // through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (clear)       count_d = '0;
    else if (enable) count_d = count_q + WIDTH'(1);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) count_q <= '0;
    else        count_q <= count_d;
  end

  assign q = count_q;

endmodule : seq_counter

// File: rtl/count_sequencer.sv
// ---------------------------------------------------------------------------
// count_sequencer
// Sequences a WIDTH-bit up-counter: on an accepted start it latches a
// terminal value and a repeat count, clears the counter, counts 0..limit
// repeatedly, flags each wrap and pulses done after the final pass.
// A repeat count of 0 runs until abort.
//   clk   : rising-edge clock
//   reset : asynchronous, active-low reset
//   bus   : count_sequencer_if.slave (start/abort/[pause]/limit/reps in,
//           ready/busy/q/wrap/done out)
// Macro COUNT_SEQ_PAUSE_EN: adds the pause input and the HOLD state.
// ---------------------------------------------------------------------------
module count_sequencer
  import count_seq_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned REPW  = DEF_REPW
) (
  input  logic              clk,
  input  logic              reset,
  count_sequencer_if.slave  bus
);

  state_e           state_d, state_q;
  logic [WIDTH-1:0] limit_d, limit_q;
  logic [REPW-1:0]  rep_d,   rep_q;
  logic [WIDTH-1:0] count;

  logic pause_w;
  logic accept;
  logic advance;
  logic wrap_w;
  logic cnt_clear;
  logic cnt_enable;

`ifdef COUNT_SEQ_PAUSE_EN
  assign pause_w = bus.pause;
`else
  assign pause_w = 1'b0;
`endif

  // abort overrides start, so a same-cycle start never opens a run.
  assign accept  = (state_q == ST_IDLE) && bus.start && !bus.abort;
  assign advance = (state_q == ST_RUN) && !pause_w;
  assign wrap_w  = advance && (count == limit_q);

  // The wrap cycle clears rather than increments, so q never exceeds limit_q.
  assign cnt_clear  = accept || wrap_w || bus.abort;
  assign cnt_enable = advance;

  seq_counter #(.WIDTH(WIDTH)) u_counter (
    .clk    (clk),
    .reset  (reset),
    .clear  (cnt_clear),
    .enable (cnt_enable),
    .q      (count)
  );

  always_comb begin
    state_d = state_q;
    limit_d = limit_q;
    rep_d   = rep_q;

    if (bus.abort) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            state_d = ST_RUN;
            limit_d = bus.limit;
            rep_d   = bus.reps;
          end
        end
        ST_RUN: begin
`ifdef COUNT_SEQ_PAUSE_EN
          if (pause_w) begin
            state_d = ST_HOLD;
          end else
`endif
          if (wrap_w) begin
            // rep_q == 0 means endless: never decremented, never finishes.
            if (rep_q == REPW'(1))    state_d = ST_DONE;
            else if (rep_q != '0)     rep_d   = rep_q - REPW'(1);
          end
        end
`ifdef COUNT_SEQ_PAUSE_EN
        ST_HOLD: begin
          if (!pause_w) state_d = ST_RUN;
        end
`endif
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      limit_q <= '0;
      rep_q   <= '0;
    end else begin
      state_q <= state_d;
      limit_q <= limit_d;
      rep_q   <= rep_d;
    end
  end

  assign bus.ready = (state_q == ST_IDLE);
  assign bus.busy  = (state_q == ST_RUN) || (state_q == ST_HOLD);
  assign bus.done  = (state_q == ST_DONE);
  assign bus.q     = count;
  assign bus.wrap  = wrap_w;

endmodule : count_sequencer

// File: tb/tb_count_sequencer.sv
// ---------------------------------------------------------------------------
// tb_count_sequencer
// Self-checking bench for count_sequencer. A run-level reference model
// (current count, latched limit, passes remaining, hold/done flags) is
// compared against the DUT on every falling edge; directed sections pin the
// model with hand-computed literal expectations, followed by random traffic.
// Honors COUNT_SEQ_PAUSE_EN when defined.
// ---------------------------------------------------------------------------
module tb_count_sequencer;

  localparam int W = 4;
  localparam int R = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  count_sequencer_if #(.WIDTH(W), .REPW(R)) bus ();

  count_sequencer #(.WIDTH(W), .REPW(R)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic pause_v;
`ifdef COUNT_SEQ_PAUSE_EN
  assign pause_v = bus.pause;
`else
  assign pause_v = 1'b0;
`endif

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (run-level view) ----------------
  bit m_run  = 1'b0;   // a run is in progress
  bit m_hold = 1'b0;   // run is frozen by pause
  bit m_done = 1'b0;   // completion cycle
  int m_q    = 0;      // position within the current 0..limit pass
  int m_lim  = 0;
  int m_rem  = 0;      // passes remaining, 0 = endless

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_run <= 1'b0; m_hold <= 1'b0; m_done <= 1'b0;
      m_q <= 0; m_lim <= 0; m_rem <= 0;
    end else if (bus.abort) begin
      m_run <= 1'b0; m_hold <= 1'b0; m_done <= 1'b0; m_q <= 0;
    end else if (m_done) begin
      m_done <= 1'b0;
    end else if (!m_run) begin
      if (bus.start) begin
        m_run <= 1'b1; m_q <= 0;
        m_lim <= int'(bus.limit);
        m_rem <= int'(bus.reps);
      end
    end else if (m_hold) begin
      if (!pause_v) m_hold <= 1'b0;
    end else if (pause_v) begin
      m_hold <= 1'b1;
    end else if (m_q == m_lim) begin
      m_q <= 0;
      if (m_rem == 1) begin
        m_run <= 1'b0; m_done <= 1'b1;
      end else if (m_rem != 0) begin
        m_rem <= m_rem - 1;
      end
    end else begin
      m_q <= m_q + 1;
    end
  end

  // ---------------- per-cycle compare ----------------
  bit chk_en = 1'b0;
  int n_done = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      check("ready", 32'(bus.ready), 32'(!m_run && !m_done));
      check("busy",  32'(bus.busy),  32'(m_run));
      check("done",  32'(bus.done),  32'(m_done));
      check("q",     32'(bus.q),     32'(m_q));
      check("wrap",  32'(bus.wrap),
            32'(m_run && !m_hold && !pause_v && (m_q == m_lim)));
      if (bus.done) n_done++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  task automatic start_run(input int lim, input int rp);
    bus.limit = W'(lim);
    bus.reps  = R'(rp);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  initial begin : stim
    int d0;
    int busy_n, wrap_n, max_q;
    bit seen_done;

    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.limit = '0;
    bus.reps  = '0;
`ifdef COUNT_SEQ_PAUSE_EN
    bus.pause = 1'b0;
`endif

    // Power-on reset: asynchronous, visible before any clock edge.
    #2 reset = 1'b0;
    chk_en = 1'b1;
    #1;
    check("rst_ready", 32'(bus.ready), 32'd1);
    check("rst_busy",  32'(bus.busy),  32'd0);
    check("rst_q",     32'(bus.q),     32'd0);
    check("rst_done",  32'(bus.done),  32'd0);
    step();
    reset = 1'b1;
    step();

    // Basic run: limit=3, reps=2.
    start_run(3, 2);
    for (int k = 0; k < 8; k++) begin
      look();
      check("basic_q",    32'(bus.q),    32'(k % 4));
      check("basic_wrap", 32'(bus.wrap), 32'(k % 4 == 3));
      step();
    end
    look();
    check("basic_done",  32'(bus.done), 32'd1);
    check("basic_busy0", 32'(bus.busy), 32'd0);
    step();
    look();
    check("basic_ready", 32'(bus.ready), 32'd1);
    check("basic_done0", 32'(bus.done),  32'd0);
    step();

    // Degenerate limit=0, reps=3.
    start_run(0, 3);
    for (int k = 0; k < 3; k++) begin
      look();
      check("lim0_q",    32'(bus.q),    32'd0);
      check("lim0_wrap", 32'(bus.wrap), 32'd1);
      step();
    end
    look();
    check("lim0_done", 32'(bus.done), 32'd1);
    step();
    step();

    // Abort together with start in IDLE: stays idle.
    bus.limit = W'(7);
    bus.reps  = R'(1);
    bus.start = 1'b1;
    bus.abort = 1'b1;
    step();
    look();
    check("abst_ready", 32'(bus.ready), 32'd1);
    check("abst_busy",  32'(bus.busy),  32'd0);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    step();

    // Start while busy with different operands: latched limit 2 holds.
    start_run(2, 1);
    bus.start = 1'b1;
    bus.limit = W'(9);
    bus.reps  = R'(5);
    for (int k = 0; k < 3; k++) begin
      look();
      check("busy_q",    32'(bus.q),    32'(k));
      check("busy_wrap", 32'(bus.wrap), 32'(k == 2));
      step();
    end
    look();
    check("busy_done", 32'(bus.done), 32'd1);
    step();
    bus.start = 1'b0;
    look();
    check("busy_ready", 32'(bus.ready), 32'd1);
    step();

    // Abort during an endless run (reps=0) at q=5.
    d0 = n_done;
    start_run(6, 0);
    repeat (19) step();
    bus.abort = 1'b1;
    look();
    check("abrt_q5",   32'(bus.q),    32'd5);
    check("abrt_busy", 32'(bus.busy), 32'd1);
    step();
    bus.abort = 1'b0;
    look();
    check("abrt_q",     32'(bus.q),     32'd0);
    check("abrt_ready", 32'(bus.ready), 32'd1);
    check("abrt_done",  32'(bus.done),  32'd0);
    repeat (3) step();
    check("abrt_nodone", 32'(n_done), 32'(d0));

    // Reset mid-count at q=3.
    start_run(7, 1);
    repeat (3) step();
    look();
    check("rmid_q3", 32'(bus.q), 32'd3);
    #2 reset = 1'b0;
    #1;
    check("rmid_q",     32'(bus.q),     32'd0);
    check("rmid_ready", 32'(bus.ready), 32'd1);
    check("rmid_busy",  32'(bus.busy),  32'd0);
    check("rmid_done",  32'(bus.done),  32'd0);
    d0 = n_done;
    step();
    reset = 1'b1;
    repeat (10) step();
    check("rmid_nodone", 32'(n_done), 32'(d0));

`ifdef COUNT_SEQ_PAUSE_EN
    // Pause at q=2: limit=5, reps=1. Unpaused, done shows 6 cycles after
    // accept; pause sampled on three edges freezes four cycles.
    begin : pause_test
      int s;
      start_run(5, 1);
      s = 0;
      seen_done = 1'b0;
      while (!seen_done && s < 40) begin
        look();
        if (bus.done) seen_done = 1'b1;
        if (s >= 3 && s <= 6) begin
          check("pause_q",    32'(bus.q),    32'd2);
          check("pause_wrap", 32'(bus.wrap), 32'd0);
        end
        if (!seen_done) begin
          bus.pause = (s >= 2 && s <= 4);
          step();
          s++;
        end
      end
      check("pause_done_at", 32'(s), 32'd10);
      bus.pause = 1'b0;
      step();
      step();
    end
`endif

    // Maximum values: limit=15, reps=15.
    busy_n = 0; wrap_n = 0; max_q = 0; seen_done = 1'b0;
    start_run(15, 15);
    for (int t = 0; t < 400 && !seen_done; t++) begin
      look();
      busy_n += int'(bus.busy);
      wrap_n += int'(bus.wrap);
      if (int'(bus.q) > max_q) max_q = int'(bus.q);
      if (bus.done) seen_done = 1'b1;
      step();
    end
    check("max_done",  32'(seen_done), 32'd1);
    check("max_busy",  32'(busy_n),    32'd240);
    check("max_wraps", 32'(wrap_n),    32'd15);
    check("max_q",     32'(max_q),     32'd15);
    look();
    check("max_ready", 32'(bus.ready), 32'd1);
    step();

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      bus.start = ($urandom_range(0, 3) == 0);
      bus.abort = ($urandom_range(0, 40) == 0);
      bus.limit = W'($urandom_range(0, 15));
      bus.reps  = R'($urandom_range(0, 3));
`ifdef COUNT_SEQ_PAUSE_EN
      bus.pause = ($urandom_range(0, 5) == 0);
`endif
      if ($urandom_range(0, 499) == 0) begin
        #2 reset = 1'b0;
        step();
        reset = 1'b1;
      end else begin
        step();
      end
    end

    bus.start = 1'b0;
    bus.abort = 1'b0;
    look();
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule : tb_count_sequencer

// File: doc/count_sequencer.md
# count_sequencer

Controller that sequences a WIDTH-bit up-counter datapath. A requester starts a run with a terminal value and a repeat count. The block then clears, enables and wraps the counter, reports each wrap, and signals completion. It sits between a requesting unit and the counter, and it owns every clear and enable decision for that counter.

## Interface
- WIDTH, 4, counter and limit width in bits
- REPW, 4, repeat-count width in bits
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  run request; accepted only while ready=1
- abort  in  1  synchronous abort; wins over every other input
- pause  in  1  freeze the counter while running (present only with COUNT_SEQ_PAUSE_EN)
- limit  in  WIDTH  terminal count, sampled on accept
- reps  in  REPW  number of 0..limit passes, sampled on accept; 0 means run until abort
- ready  out  1  idle and able to accept start
- busy  out  1  run in progress (RUN or HOLD)
- q  out  WIDTH  current count
- wrap  out  1  high in the advancing cycle where q==limit_r
- done  out  1  one-cycle pulse after the final wrap

## Operation
- States: IDLE, RUN, HOLD, DONE. Encoding is binary, 2 bits.
- IDLE: ready=1. If start=1 and abort=0, the block latches limit_r<=limit, rep_r<=reps and q<=0, then goes to RUN.
- RUN: if pause=1, go to HOLD and hold q. Otherwise q increments.
  - When q==limit_r, wrap=1 and q<=0.
  - If rep_r==1 at that wrap, go to DONE. Otherwise rep_r decrements.
  - If rep_r==0, the block never decrements and never finishes.
- HOLD: q, rep_r and wrap are frozen, and wrap=0. When pause=0, go back to RUN. The count resumes where it left off.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE. A start during DONE is ignored.
- abort=1 in any state: the next state is IDLE, q<=0, and no done pulse is issued. A start in the same cycle is ignored.
- start while busy: ignored. Latched limit_r and rep_r are never modified during a run.
- limit=0: every advancing RUN cycle is a wrap, and q stays 0.
- Arithmetic: q is modulo 2^WIDTH, but it never passes limit_r. rep_r decrements without wrapping below 1.
- wrap = (state==RUN) && !pause && (q==limit_r). This is combinational from registers and pause. All other outputs come from registers or state decode.

## Timing
- Reset asserted: state=IDLE, q=0, limit_r=0, rep_r=0, ready=1, busy=0, wrap=0, done=0. Reset takes effect immediately, without waiting for a clock edge.
- Reset deasserted mid-run: the block restarts in IDLE. No wrap or done is produced for the interrupted run.
- Start accepted at edge N: after N, busy=1 and q=0. After N+k, q=k for k≤limit.
- Uninterrupted run length: reps×(limit+1) RUN cycles, then one DONE cycle, then ready=1 on the next cycle.
- Each HOLD cycle extends the run by exactly one cycle.
- Earliest next accept: the first edge where ready=1 after DONE, which is two edges after the final wrap.

## Configuration
- COUNT_SEQ_PAUSE_EN defined: the pause port and the HOLD state exist, as described above.
- COUNT_SEQ_PAUSE_EN undefined: the pause port is removed and HOLD is not compiled.
  - RUN advances every cycle.
  - wrap = (state==RUN) && (q==limit_r).
  - All other behaviour is identical.

## Structure
- Shared package count_seq_pkg holds:
  - the state encoding constants ST_IDLE=0, ST_RUN=1, ST_HOLD=2, ST_DONE=3;
  - the default WIDTH and REPW values.
- Sub-module seq_counter is the WIDTH-bit synchronous counter. It has a clear input and an enable input and shares the same asynchronous active-low reset. count_sequencer drives clear on accept, wrap or abort, and drives enable in advancing RUN cycles.
- The FSM, the limit_r/rep_r registers and the output decode stay in count_sequencer.

## Test plan
- Reset mid-count: assert reset while q=3 in RUN → q=0, ready=1, busy=0 immediately, and no done pulse is issued.
- Basic run: limit=3, reps=2, start for 1 cycle → q goes 0,1,2,3,0,1,2,3; wrap high when q=3 (twice); done pulses once 8 cycles after accept; ready=1 one cycle later.
- Degenerate limit: limit=0, reps=3 → q stays 0, wrap is high 3 consecutive cycles, then done.
- Pause (macro defined): limit=5, reps=1, pause held 4 cycles at q=2 → q holds 2 and wrap=0 throughout; done arrives exactly 4 cycles later than without pause.
- Abort and ignored starts: abort with start high in the same IDLE cycle → stays IDLE. Start while busy → limit_r unchanged. Abort during reps=0 run at q=5 → IDLE next cycle, q=0, no done.
- Maximum values: limit=15, reps=15 → exactly 240 RUN cycles, 15 wraps, one done; q never exceeds 15.
